// File: rtl/sha3_pkg.sv
// Shared definitions for the SHA3 stream padder.
//    sha3_mode_e : digest selector carried on S_TUSER / BLK_MODE
//    rate_bytes  : rate r in bytes for a given mode
//    PAD_DOMAIN / PAD_FINAL : SHA3 domain-separation byte and final pad bit
//    MAX_RATE    : width in bits of the block register (SHA3-224 rate)
package sha3_pkg;

   localparam int         MAX_RATE   = 1152;
   localparam int         PTR_W      = 8;      // byte offsets up to 144 + one word
   localparam logic [7:0] PAD_DOMAIN = 8'h06;
   localparam logic [7:0] PAD_FINAL  = 8'h80;

   typedef enum logic [1:0] {
      MODE_224 = 2'd0,
      MODE_256 = 2'd1,
      MODE_384 = 2'd2,
      MODE_512 = 2'd3
   } sha3_mode_e;

   function automatic logic [PTR_W-1:0] rate_bytes(input sha3_mode_e mode);
      logic [PTR_W-1:0] r;
      case (mode)
         MODE_224: r = 8'd144;
         MODE_256: r = 8'd136;
         MODE_384: r = 8'd104;
         default:  r = 8'd72;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/sha3_pad_inserter.sv
// Combinational byte merger for the SHA3 padder.
//    blk_i   : current block register contents (Keccak lane order, byte j at [8j+7:8j])
//    data_i  : input word, first stream byte in the MSB byte
//    keep_i  : per-byte qualifier for data_i (bit k qualifies byte k)
//    wr_i    : write the qualified bytes of data_i starting at byte offset p_i
//    pend_i  : end offset p' of the message inside this block
//    pad_i   : apply the SHA3 pad (0x06 at p', 0x80 at r-1)
//    mode_i  : mode selecting the rate r
//    blk_o   : merged block
module sha3_pad_inserter #(
   parameter int WIDTH    = 16,
   parameter int MAX_RATE = sha3_pkg::MAX_RATE
) (
   input  logic [MAX_RATE-1:0]         blk_i,
   input  logic [WIDTH-1:0]            data_i,
   input  logic [WIDTH/8-1:0]          keep_i,
   input  logic                        wr_i,
   input  logic [sha3_pkg::PTR_W-1:0]  p_i,
   input  logic [sha3_pkg::PTR_W-1:0]  pend_i,
   input  logic                        pad_i,
   input  logic [1:0]                  mode_i,
   output logic [MAX_RATE-1:0]         blk_o
);
   import sha3_pkg::*;

   localparam int NB     = WIDTH / 8;
   localparam int NBYTES = MAX_RATE / 8;

   logic [PTR_W-1:0] rate;

   assign rate = rate_bytes(sha3_mode_e'(mode_i));

   // Data is written first and the pad XORed on top, so when p' = r-1 the
   // still-empty byte becomes 0x06 ^ 0x80 = 0x86 without a special case.
   always_comb begin
      blk_o = blk_i;
      for (int j = 0; j < NBYTES; j++) begin
         for (int k = 0; k < NB; k++) begin
            if (wr_i && keep_i[k] && (j == int'(p_i) + k))
               blk_o[8*j +: 8] = data_i[WIDTH-1-8*k -: 8];
         end
         if (pad_i && (j == int'(pend_i)))
            blk_o[8*j +: 8] = blk_o[8*j +: 8] ^ PAD_DOMAIN;
         if (pad_i && (j == int'(rate) - 1))
            blk_o[8*j +: 8] = blk_o[8*j +: 8] ^ PAD_FINAL;
      end
   end

endmodule

// File: rtl/sha3_stream_padder.sv
// SHA3 stream padder: packs an AXI-Stream byte message into rate-sized
// blocks, applies the SHA3 pad, and hands each block to a permutation core.
//    ACLK, ARESET          : clock, synchronous active-high reset
//    S_TDATA/TKEEP/TLAST   : message words (first byte in MSB), tail qualifier
//    S_TUSER               : mode, sampled on the first word of a message
//    S_TVALID/S_TREADY     : input handshake
//    BLK_DATA/MODE/LAST    : padded block, its mode, final-block flag
//    BLK_VALID/BLK_READY   : block handshake
//
// state  | meaning
// ABSORB | accepting words into the block register at byte offset p
// EMIT   | block register complete, offered on BLK_*
// PADBLK | building a pad-only block after a message that filled its block
module sha3_stream_padder #(
   parameter int WIDTH    = 16,
   parameter int MAX_RATE = sha3_pkg::MAX_RATE
) (
   input  logic                  ACLK,
   input  logic                  ARESET,
   input  logic [WIDTH-1:0]      S_TDATA,
   input  logic [WIDTH/8-1:0]    S_TKEEP,
   input  logic                  S_TLAST,
   input  logic [1:0]            S_TUSER,
   input  logic                  S_TVALID,
   output logic                  S_TREADY,
   output logic [MAX_RATE-1:0]   BLK_DATA,
   output logic [1:0]            BLK_MODE,
   output logic                  BLK_LAST,
   output logic                  BLK_VALID,
   input  logic                  BLK_READY
);
   import sha3_pkg::*;

   localparam int NB = WIDTH / 8;

   localparam logic [1:0] ST_ABSORB = 2'd0;
   localparam logic [1:0] ST_EMIT   = 2'd1;
   localparam logic [1:0] ST_PADBLK = 2'd2;

   logic [1:0]          state_q, state_d;
   logic [PTR_W-1:0]    p_q, p_d;
   logic [MAX_RATE-1:0] blk_q, blk_d;
   logic [1:0]          mode_q, mode_d;
   logic                last_q, last_d;
   logic                first_q, first_d;   // next accepted word starts a message
   logic                padp_q, padp_d;     // pad-only block still owed

   logic [1:0]          mode_eff;
   logic [PTR_W-1:0]    rate;
   logic [PTR_W-1:0]    kept;
   logic [PTR_W-1:0]    p_end;

   logic                ins_wr;
   logic                ins_pad;
   logic [PTR_W-1:0]    ins_p;
   logic [PTR_W-1:0]    ins_pend;
   logic [NB-1:0]       ins_keep;
   logic [1:0]          ins_mode;
   logic [MAX_RATE-1:0] ins_blk;

   assign mode_eff = first_q ? S_TUSER : mode_q;
   assign rate     = rate_bytes(sha3_mode_e'(mode_eff));

   // Keep is only meaningful on the last word; earlier words are always full.
   always_comb begin
      kept = '0;
      for (int k = 0; k < NB; k++)
         kept = kept + PTR_W'(S_TKEEP[k]);
   end

   assign p_end = p_q + (S_TLAST ? kept : PTR_W'(NB));

   sha3_pad_inserter #(
      .WIDTH    (WIDTH),
      .MAX_RATE (MAX_RATE)
   ) u_pad (
      .blk_i  (blk_q),
      .data_i (S_TDATA),
      .keep_i (ins_keep),
      .wr_i   (ins_wr),
      .p_i    (ins_p),
      .pend_i (ins_pend),
      .pad_i  (ins_pad),
      .mode_i (ins_mode),
      .blk_o  (ins_blk)
   );

   always_comb begin
      state_d  = state_q;
      p_d      = p_q;
      blk_d    = blk_q;
      mode_d   = mode_q;
      last_d   = last_q;
      first_d  = first_q;
      padp_d   = padp_q;
      ins_wr   = 1'b0;
      ins_pad  = 1'b0;
      ins_p    = p_q;
      ins_pend = p_q;
      ins_keep = '1;
      ins_mode = mode_q;

      case (state_q)
         ST_ABSORB: begin
            ins_mode = mode_eff;
            ins_keep = S_TLAST ? S_TKEEP : '1;
            ins_pend = p_end;
            ins_pad  = S_TLAST && (p_end < rate);
            if (S_TVALID) begin
               ins_wr  = 1'b1;
               blk_d   = ins_blk;
               mode_d  = mode_eff;
               first_d = S_TLAST;
               if (S_TLAST) begin
                  // A message ending exactly on the rate boundary has no room
                  // for the pad: emit the data block, then a pad-only block.
                  p_d     = '0;
                  state_d = ST_EMIT;
                  last_d  = (p_end < rate);
                  padp_d  = (p_end >= rate);
               end else if (p_end >= rate) begin
                  p_d     = '0;
                  state_d = ST_EMIT;
                  last_d  = 1'b0;
               end else begin
                  p_d = p_end;
               end
            end
         end
         ST_EMIT: begin
            if (BLK_READY) begin
               blk_d   = '0;
               last_d  = 1'b0;
               padp_d  = 1'b0;
               state_d = padp_q ? ST_PADBLK : ST_ABSORB;
            end
         end
         ST_PADBLK: begin
            ins_p    = '0;
            ins_pend = '0;
            ins_pad  = 1'b1;
            blk_d    = ins_blk;
            last_d   = 1'b1;
            state_d  = ST_EMIT;
         end
         default: state_d = ST_ABSORB;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q <= ST_ABSORB;
         p_q     <= '0;
         blk_q   <= '0;
         mode_q  <= '0;
         last_q  <= 1'b0;
         first_q <= 1'b1;
         padp_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         p_q     <= p_d;
         blk_q   <= blk_d;
         mode_q  <= mode_d;
         last_q  <= last_d;
         first_q <= first_d;
         padp_q  <= padp_d;
      end
   end

   assign S_TREADY  = (state_q == ST_ABSORB);
   assign BLK_VALID = (state_q == ST_EMIT);
   assign BLK_DATA  = blk_q;
   assign BLK_MODE  = mode_q;
   assign BLK_LAST  = last_q;

endmodule
